sram_req_arbiter: RTL and testbench

- Shares one sram-like slave port (towards the AXI bridge or cache) between the fetch-side and memory-side sram-like masters.
- Selects one request per cycle with data-side priority, plus a starvation guard for fetch and a grant lock while a request awaits addr_ok.
- Tracks in-order outstanding transactions in an ID FIFO, so each data_ok/rdata beat returns to the master that issued it.
- Sits between Fetch/Mem stages and the bus bridge.

---
 rtl/sram_req_arbiter_if.sv | 24 ++
 rtl/sram_req_arbiter.sv | 97 +++++++++
 tb/tb_sram_req_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_arbiter_if.sv
// sram_req_arbiter_if: sram-like request/response bundle shared by fetch, data and the downstream slave port.
// Signals: req/wr/size/wstrb/addr/wdata travel master->slave, addr_ok/data_ok/rdata travel slave->master.
// Modports: master (issues requests), slave (accepts requests and returns responses).
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram-like slave port between fetch and data masters with data priority,
// a fetch starvation guard, a grant lock until addr_ok, and an in-order ID FIFO for response routing.
// Ports: clk, rstn (sync, active-low); inst/data (slave side of each master); m (towards bridge);
// ost_cnt (registered outstanding count); err_spurious (sticky, data_ok seen with nothing outstanding).
module sram_req_arbiter #(
    parameter int OST_DEPTH    = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    sram_req_arbiter_if.slave          inst,
    sram_req_arbiter_if.slave          data,
    sram_req_arbiter_if.master         m,
    output logic [$clog2(OST_DEPTH):0] ost_cnt,
    output logic                       err_spurious
);
    localparam int PW = $clog2(OST_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = STARVE_LIMIT < 1 ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [OST_DEPTH-1:0] ids;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [SW-1:0]        starve_cnt;
    logic                 lock;
    logic                 lock_sel;
    logic                 sel;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 head;
    logic                 locked_req;

    assign full  = ost_cnt == CW'(OST_DEPTH);
    assign empty = ost_cnt == '0;

    // sel: 1 = data, 0 = inst; fetch wins a contested cycle only once it has been starved long enough
    always_comb begin
        sel = lock ? lock_sel
            : (inst.req && data.req) ? (starve_cnt < SW'(STARVE_LIMIT))
            : data.req;
    end

    assign m.req   = rstn && !full && (sel ? data.req : inst.req);
    assign m.wr    = sel ? data.wr    : inst.wr;
    assign m.size  = sel ? data.size  : inst.size;
    assign m.wstrb = sel ? data.wstrb : inst.wstrb;
    assign m.addr  = sel ? data.addr  : inst.addr;
    assign m.wdata = sel ? data.wdata : inst.wdata;

    assign push = m.req && m.addr_ok;
    assign head = ids[rd_ptr];
    // responses are only routed while out of reset and something is outstanding
    assign pop  = rstn && m.data_ok && !empty;

    assign data.addr_ok = push && sel;
    assign inst.addr_ok = push && !sel;
    assign data.data_ok = pop && head;
    assign inst.data_ok = pop && !head;
    assign data.rdata   = m.rdata;
    assign inst.rdata   = m.rdata;

    assign locked_req = lock_sel ? data.req : inst.req;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ost_cnt      <= '0;
            starve_cnt   <= '0;
            lock         <= 1'b0;
            lock_sel     <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (push) begin
                ids[wr_ptr] <= sel;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            ost_cnt      <= ost_cnt + CW'(push) - CW'(pop);
            err_spurious <= err_spurious | (m.data_ok && empty);
            // hold the grant while a presented request waits; release on acceptance or withdrawal
            if (m.req && !m.addr_ok) begin
                lock     <= 1'b1;
                lock_sel <= sel;
            end else if (push || (lock && !locked_req)) begin
                lock <= 1'b0;
            end
            if (!inst.req || (push && !sel))
                starve_cnt <= '0;
            else if (push && sel && starve_cnt < SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed self-checking bench for sram_req_arbiter (OST_DEPTH=4, STARVE_LIMIT=3).
module tb_sram_req_arbiter;
    localparam logic [31:0] IA = 32'h1c00_0000;
    localparam logic [31:0] DA = 32'h1c00_1000;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] ost_cnt;
    logic       err_spurious;
    int         checks = 0;
    int         fails  = 0;

    sram_req_arbiter_if inst_if ();
    sram_req_arbiter_if data_if ();
    sram_req_arbiter_if m_if ();

    sram_req_arbiter #(.OST_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .inst         (inst_if),
        .data         (data_if),
        .m            (m_if),
        .ost_cnt      (ost_cnt),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle;
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.wstrb = 4'h0;
        inst_if.addr = IA; inst_if.wdata = 32'h0;
        data_if.req = 0; data_if.wr = 1; data_if.size = 2'd2; data_if.wstrb = 4'hf;
        data_if.addr = DA; data_if.wdata = 32'hdead_beef;
        m_if.addr_ok = 0; m_if.data_ok = 0; m_if.rdata = 32'h0;
    endtask

    task automatic test_reset;
        idle();
        rstn = 0;
        inst_if.req = 1; data_if.req = 1; m_if.addr_ok = 1; m_if.data_ok = 1;
        settle();
        checks++;
        if (m_if.req !== 1'b0) begin fails++; $display("FAIL reset_m_req got %b want 0", m_if.req); end
        checks++;
        if ({inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 4'b0) begin
            fails++; $display("FAIL reset_oks got %b want 0000",
                {inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok});
        end
        tick();
        checks++;
        if (ost_cnt !== 3'd0 || err_spurious !== 1'b0) begin
            fails++; $display("FAIL reset_state got ost=%0d err=%b want 0 0", ost_cnt, err_spurious);
        end
        idle();
        rstn = 1;
        tick();
    endtask

    task automatic test_single_inst;
        inst_if.req = 1; m_if.addr_ok = 1;
        settle();
        checks++;
        if (m_if.req !== 1'b1 || m_if.addr !== IA || inst_if.addr_ok !== 1'b1 || data_if.addr_ok !== 1'b0) begin
            fails++; $display("FAIL single_req got req=%b addr=%h iok=%b dok=%b want 1 %h 1 0",
                m_if.req, m_if.addr, inst_if.addr_ok, data_if.addr_ok, IA);
        end
        tick();
        checks++;
        if (ost_cnt !== 3'd1) begin fails++; $display("FAIL single_ost1 got %0d want 1", ost_cnt); end
        inst_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1; m_if.rdata = 32'h0280_0000;
        settle();
        checks++;
        if (inst_if.data_ok !== 1'b1 || data_if.data_ok !== 1'b0 || inst_if.rdata !== 32'h0280_0000) begin
            fails++; $display("FAIL single_resp got iok=%b dok=%b rdata=%h want 1 0 02800000",
                inst_if.data_ok, data_if.data_ok, inst_if.rdata);
        end
        tick();
        m_if.data_ok = 0;
        checks++;
        if (ost_cnt !== 3'd0) begin fails++; $display("FAIL single_ost0 got %0d want 0", ost_cnt); end
    endtask

    task automatic test_starvation;
        logic [7:0] order;
        logic       prev;
        order = 8'h77;
        prev  = 1'b0;
        inst_if.req = 1; data_if.req = 1; m_if.addr_ok = 1;
        for (int k = 0; k < 8; k++) begin
            m_if.data_ok = (k > 0);
            m_if.rdata   = 32'h100 + k;
            settle();
            checks++;
            if (m_if.addr !== (order[k] ? DA : IA) || data_if.addr_ok !== order[k] || inst_if.addr_ok !== !order[k]) begin
                fails++; $display("FAIL starve_grant%0d got addr=%h dok=%b iok=%b want addr=%h",
                    k, m_if.addr, data_if.addr_ok, inst_if.addr_ok, order[k] ? DA : IA);
            end
            if (k > 0) begin
                checks++;
                if (data_if.data_ok !== prev || inst_if.data_ok !== !prev) begin
                    fails++; $display("FAIL starve_route%0d got d=%b i=%b want d=%b",
                        k, data_if.data_ok, inst_if.data_ok, prev);
                end
            end
            prev = order[k];
            tick();
        end
        inst_if.req = 0; data_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1;
        settle();
        checks++;
        if (inst_if.data_ok !== 1'b1 || data_if.data_ok !== 1'b0) begin
            fails++; $display("FAIL starve_last got i=%b d=%b want 1 0", inst_if.data_ok, data_if.data_ok);
        end
        tick();
        m_if.data_ok = 0;
        checks++;
        if (ost_cnt !== 3'd0) begin fails++; $display("FAIL starve_drain got %0d want 0", ost_cnt); end
    endtask

    task automatic test_lock;
        data_if.req = 1; m_if.addr_ok = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) inst_if.req = 1;
            settle();
            checks++;
            if (m_if.req !== 1'b1 || m_if.addr !== DA || inst_if.addr_ok !== 1'b0) begin
                fails++; $display("FAIL lock_hold%0d got req=%b addr=%h iok=%b want 1 %h 0",
                    k, m_if.req, m_if.addr, inst_if.addr_ok, DA);
            end
            tick();
        end
        m_if.addr_ok = 1;
        settle();
        checks++;
        if (data_if.addr_ok !== 1'b1 || inst_if.addr_ok !== 1'b0) begin
            fails++; $display("FAIL lock_accept got dok=%b iok=%b want 1 0", data_if.addr_ok, inst_if.addr_ok);
        end
        tick();
        data_if.req = 0;
        settle();
        checks++;
        if (m_if.addr !== IA || inst_if.addr_ok !== 1'b1) begin
            fails++; $display("FAIL lock_inst_after got addr=%h iok=%b want %h 1", m_if.addr, inst_if.addr_ok, IA);
        end
        tick();
        inst_if.req = 0; m_if.addr_ok = 0;
        for (int k = 0; k < 2; k++) begin
            m_if.data_ok = 1;
            settle();
            checks++;
            if (data_if.data_ok !== (k == 0) || inst_if.data_ok !== (k == 1)) begin
                fails++; $display("FAIL lock_route%0d got d=%b i=%b want d=%b", k, data_if.data_ok, inst_if.data_ok, k == 0);
            end
            tick();
        end
        m_if.data_ok = 0;
        inst_if.req = 1;
        tick();
        data_if.req = 1;
        settle();
        checks++;
        if (m_if.addr !== IA || m_if.req !== 1'b1) begin
            fails++; $display("FAIL lock_inst_held got addr=%h req=%b want %h 1", m_if.addr, m_if.req, IA);
        end
        tick();
        inst_if.req = 0;
        settle();
        checks++;
        if (m_if.req !== 1'b0) begin fails++; $display("FAIL lock_drop_cycle got req=%b want 0", m_if.req); end
        tick();
        checks++;
        if (m_if.req !== 1'b1 || m_if.addr !== DA) begin
            fails++; $display("FAIL lock_released got req=%b addr=%h want 1 %h", m_if.req, m_if.addr, DA);
        end
        data_if.req = 0;
        tick();
    endtask

    task automatic test_full;
        data_if.req = 1; m_if.addr_ok = 1;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (ost_cnt !== 3'd4) begin fails++; $display("FAIL full_cnt got %0d want 4", ost_cnt); end
        checks++;
        if (m_if.req !== 1'b0 || data_if.addr_ok !== 1'b0) begin
            fails++; $display("FAIL full_block got req=%b dok=%b want 0 0", m_if.req, data_if.addr_ok);
        end
        m_if.data_ok = 1;
        settle();
        checks++;
        if (m_if.req !== 1'b0 || data_if.data_ok !== 1'b1) begin
            fails++; $display("FAIL full_pop_cycle got req=%b dataok=%b want 0 1", m_if.req, data_if.data_ok);
        end
        tick();
        m_if.data_ok = 0;
        checks++;
        if (ost_cnt !== 3'd3 || m_if.req !== 1'b1) begin
            fails++; $display("FAIL full_freed got ost=%0d req=%b want 3 1", ost_cnt, m_if.req);
        end
        data_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1;
        for (int k = 0; k < 3; k++) tick();
        m_if.data_ok = 0;
        checks++;
        if (ost_cnt !== 3'd0) begin fails++; $display("FAIL full_drain got %0d want 0", ost_cnt); end
    endtask

    task automatic test_order;
        logic [2:0] who;
        who = 3'b010;
        m_if.addr_ok = 1;
        for (int k = 0; k < 3; k++) begin
            inst_if.req = !who[k]; data_if.req = who[k];
            tick();
        end
        inst_if.req = 0; data_if.req = 0; m_if.addr_ok = 0;
        for (int k = 0; k < 3; k++) begin
            m_if.data_ok = 1; m_if.rdata = 32'hab00_0000 + k;
            settle();
            checks++;
            if (data_if.data_ok !== who[k] || inst_if.data_ok !== !who[k] || data_if.rdata !== 32'hab00_0000 + k) begin
                fails++; $display("FAIL order%0d got d=%b i=%b rdata=%h want d=%b rdata=%h",
                    k, data_if.data_ok, inst_if.data_ok, data_if.rdata, who[k], 32'hab00_0000 + k);
            end
            tick();
        end
        m_if.data_ok = 0;
    endtask

    task automatic test_spurious;
        m_if.data_ok = 1;
        settle();
        checks++;
        if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0) begin
            fails++; $display("FAIL spur_route got i=%b d=%b want 0 0", inst_if.data_ok, data_if.data_ok);
        end
        tick();
        m_if.data_ok = 0;
        tick();
        checks++;
        if (err_spurious !== 1'b1 || ost_cnt !== 3'd0) begin
            fails++; $display("FAIL spur_sticky got err=%b ost=%0d want 1 0", err_spurious, ost_cnt);
        end
        inst_if.req = 1; m_if.addr_ok = 1;
        tick();
        tick();
        checks++;
        if (ost_cnt !== 3'd2) begin fails++; $display("FAIL spur_two_ost got %0d want 2", ost_cnt); end
        rstn = 0;
        settle();
        checks++;
        if (m_if.req !== 1'b0 || inst_if.addr_ok !== 1'b0) begin
            fails++; $display("FAIL spur_rst_req got req=%b iok=%b want 0 0", m_if.req, inst_if.addr_ok);
        end
        tick();
        checks++;
        if (ost_cnt !== 3'd0 || err_spurious !== 1'b0) begin
            fails++; $display("FAIL spur_rst_state got ost=%0d err=%b want 0 0", ost_cnt, err_spurious);
        end
        rstn = 1; inst_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1;
        settle();
        checks++;
        if (inst_if.data_ok !== 1'b0) begin fails++; $display("FAIL spur_late got i=%b want 0", inst_if.data_ok); end
        tick();
        m_if.data_ok = 0;
        checks++;
        if (err_spurious !== 1'b1) begin fails++; $display("FAIL spur_late_err got %b want 1", err_spurious); end
    endtask

    initial begin
        rstn = 0;
        idle();
        tick();
        test_reset();
        test_single_inst();
        test_starvation();
        test_lock();
        test_full();
        test_order();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
